shift_seq_ctrl: RTL

//  Command-driven sequencer for a WIDTH-bit bidirectional serial-in shift register.

---
 rtl/shift_seq_ctrl_pkg.sv | 13 +
 rtl/shift_reg_core.sv | 32 +++
 rtl/shift_seq_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared state encoding and direction constants
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_reg_core.sv
// rtl/shift_reg_core.sv - bidirectional serial-in shift register with sync clear
module shift_reg_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             left,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);
  import shift_seq_ctrl_pkg::*;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      if (left == DIR_LEFT) q_d = {q_q[WIDTH-2:0], ser_in};
      else                  q_d = {ser_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer feeding a parallel word serially into shift_reg_core
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_left,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             ser_bit,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);
  import shift_seq_ctrl_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             left_q, left_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_rev;
  logic [WIDTH-1:0] data_sh;
  logic             tick;

  // Left commands are stored bit-reversed so both directions emit data_q[bit_cnt].
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < WIDTH; i++) data_rev[i] = cmd_data[WIDTH-1-i];
  end

  assign tick      = (state_q == ST_SHIFT) && (div_cnt_q == DW'(DIV - 1));
  assign data_sh   = data_q >> bit_cnt_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign shift_en  = tick;
  assign ser_bit   = (state_q == ST_SHIFT) & data_sh[0];
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    data_d    = data_q;
    left_d    = left_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          data_d    = (cmd_left == DIR_LEFT) ? data_rev : cmd_data;
          left_d    = cmd_left;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (tick) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      data_q    <= '0;
      left_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      data_q    <= data_d;
      left_q    <= left_d;
      done_q    <= done_d;
    end
  end

  // Abort takes priority over a shift due on the same edge.
  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .clr_n  (rst_n),
    .en     (tick & ~abort),
    .left   (left_q),
    .ser_in (ser_bit),
    .q      (q)
  );

endmodule
